matrix_result_drain: RTL and testbench



---
 rtl/matrix_pkg.sv | 16 +
 rtl/mm_index_counter.sv | 69 ++++++
 rtl/matrix_result_drain.sv | 104 ++++++++++
 tb/tb_matrix_result_drain.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared sizing and state types for the 3x3 matrix result path.
// Build option MATRIX_DRAIN_TRANSPOSE_EN (column-major drain order) is consumed by mm_index_counter.
package matrix_pkg;

    localparam int DATA_W   = 8;
    localparam int DIM      = 3;
    localparam int NUM_ELEM = DIM * DIM;
    localparam int IDX_W    = $clog2(NUM_ELEM);
    localparam int RC_W     = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

endpackage

// File: rtl/mm_index_counter.sv
// Row/col walker with enable, sync clear and wrap; registered position plus one-step lookahead, zero latency.
// No backpressure of its own: holds while en=0. MATRIX_DRAIN_TRANSPOSE_EN walks column-major instead of row-major.
module mm_index_counter
    import matrix_pkg::*;
#(
    parameter int SIDE     = DIM,
    parameter int IDX_BITS = IDX_W,
    parameter int RC_BITS  = RC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                en,
    output logic [RC_BITS-1:0]  row,
    output logic [RC_BITS-1:0]  col,
    output logic [IDX_BITS-1:0] flat,
    output logic                at_last,
    output logic [IDX_BITS-1:0] nxt_flat,
    output logic                nxt_at_last
);

    localparam logic [RC_BITS-1:0] EDGE = RC_BITS'(SIDE - 1);

    logic [RC_BITS-1:0] nxt_row;
    logic [RC_BITS-1:0] nxt_col;

    always_comb begin
        nxt_row = row;
        nxt_col = col;
`ifdef MATRIX_DRAIN_TRANSPOSE_EN
        if (row == EDGE) begin
            nxt_row = '0;
            nxt_col = (col == EDGE) ? '0 : col + 1'b1;
        end else begin
            nxt_row = row + 1'b1;
        end
`else
        if (col == EDGE) begin
            nxt_col = '0;
            nxt_row = (row == EDGE) ? '0 : row + 1'b1;
        end else begin
            nxt_col = col + 1'b1;
        end
`endif
        // flat always names the source position, whatever the walk order
        nxt_flat    = IDX_BITS'(32'(nxt_row) * SIDE + 32'(nxt_col));
        nxt_at_last = (nxt_row == EDGE) && (nxt_col == EDGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row     <= '0;
            col     <= '0;
            flat    <= '0;
            at_last <= 1'b0;
        end else if (clear) begin
            row     <= '0;
            col     <= '0;
            flat    <= '0;
            at_last <= (SIDE == 1);
        end else if (en) begin
            row     <= nxt_row;
            col     <= nxt_col;
            flat    <= nxt_flat;
            at_last <= nxt_at_last;
        end
    end

endmodule

// File: rtl/matrix_result_drain.sv
// Snapshots the 3x3 product on done and streams it out one word per valid/ready beat; first beat 1 cycle after done.
// Output regs hold while out_ready=0; done during a stream is dropped and flagged. MATRIX_DRAIN_TRANSPOSE_EN = column-major.
module matrix_result_drain #(
    parameter int DATA_W = matrix_pkg::DATA_W,
    parameter int DIM    = matrix_pkg::DIM
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      done,
    input  logic [DIM*DIM*DATA_W-1:0] m_flat,
    output logic [DATA_W-1:0]         out_data,
    output logic [1:0]                out_row,
    output logic [1:0]                out_col,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overrun
);
    import matrix_pkg::*;

    localparam int N_ELEM = DIM * DIM;
    localparam int IX_W   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    drain_state_t      state;
    logic [DATA_W-1:0] snap [N_ELEM];

    logic [1:0]      row;
    logic [1:0]      col;
    logic [IX_W-1:0] flat;
    logic [IX_W-1:0] nxt_flat;
    logic            at_last;
    logic            nxt_at_last;

    logic hs;
    logic last_hs;
    logic capture;
    logic cnt_clr;
    logic cnt_en;

    always_comb begin
        hs      = out_valid && out_ready;
        last_hs = (state == STREAM) && hs && at_last;
        // a done landing on the final beat is a legal back-to-back launch
        capture = done && ((state == IDLE) || last_hs);
        cnt_clr = capture || last_hs;
        cnt_en  = (state == STREAM) && hs && !at_last;
    end

    mm_index_counter #(
        .SIDE     (DIM),
        .IDX_BITS (IX_W),
        .RC_BITS  (2)
    ) u_idx (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clr),
        .en          (cnt_en),
        .row         (row),
        .col         (col),
        .flat        (flat),
        .at_last     (at_last),
        .nxt_flat    (nxt_flat),
        .nxt_at_last (nxt_at_last)
    );

    assign out_row = row;
    assign out_col = col;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int n = 0; n < N_ELEM; n++) snap[n] <= '0;
        end else begin
            if (done && (state == STREAM) && !last_hs) overrun <= 1'b1;

            if (capture) begin
                for (int n = 0; n < N_ELEM; n++) snap[n] <= m_flat[n*DATA_W +: DATA_W];
                out_data  <= m_flat[DATA_W-1:0];
                out_valid <= 1'b1;
                out_last  <= (N_ELEM == 1);
                busy      <= 1'b1;
                state     <= STREAM;
            end else if (last_hs) begin
                out_data  <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                state     <= IDLE;
            end else if (cnt_en) begin
                out_data  <= snap[nxt_flat];
                out_last  <= nxt_at_last;
            end
        end
    end

    flat_in_range: assert property (@(posedge clk) disable iff (!reset) flat < IX_W'(N_ELEM));

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed self-checking bench for matrix_result_drain; honours MATRIX_DRAIN_TRANSPOSE_EN for the expected order.
module tb_matrix_result_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        done;
    logic [71:0] m_flat;
    logic [7:0]  out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int order [9];

    typedef struct {
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_row;
        logic [1:0] exp_col;
        logic       exp_last;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [11];

    matrix_result_drain dut (
        .clk       (clk),
        .reset     (rst_n),
        .done      (done),
        .m_flat    (m_flat),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] base);
        for (int n = 0; n < 9; n++) m_flat[n*8 +: 8] = base + 8'(n);
    endtask

    task automatic expect_elem(input string tag, input logic [7:0] base, input int k);
        int n;
        n = order[k];
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_data"},  32'(out_data),  32'(base + 8'(n)));
        chk({tag, "_row"},   32'(out_row),   n / 3);
        chk({tag, "_col"},   32'(out_col),   n % 3);
        chk({tag, "_last"},  32'(out_last),  (k == 8) ? 1 : 0);
    endtask

    task automatic drain_rest(input string tag, input logic [7:0] base, input int from);
        out_ready = 1'b1;
        for (int k = from; k < 9; k++) begin
            expect_elem(tag, base, k);
            step();
        end
        chk({tag, "_end_valid"}, 32'(out_valid), 0);
        chk({tag, "_end_busy"},  32'(busy), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int pat [4];
        int hs;
        logic prev_stall;
        logic [7:0] prev_data;

`ifdef MATRIX_DRAIN_TRANSPOSE_EN
        order = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
        vecs[0]  = '{1'b1, 1'b1, 8'd1, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'd4, 2'd1, 2'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'd4, 2'd1, 2'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'd7, 2'd2, 2'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'd2, 2'd0, 2'd1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 8'd5, 2'd1, 2'd1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'd8, 2'd2, 2'd1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 8'd3, 2'd0, 2'd2, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'd6, 2'd1, 2'd2, 1'b0, 1'b1};
`else
        order = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        vecs[0]  = '{1'b1, 1'b1, 8'd1, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'd2, 2'd0, 2'd1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'd2, 2'd0, 2'd1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'd3, 2'd0, 2'd2, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'd4, 2'd1, 2'd0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 8'd5, 2'd1, 2'd1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'd6, 2'd1, 2'd2, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 8'd7, 2'd2, 2'd0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'd8, 2'd2, 2'd1, 1'b0, 1'b1};
`endif
        vecs[9]  = '{1'b1, 1'b1, 8'd9, 2'd2, 2'd2, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        pat = '{1, 0, 0, 1};

        rst_n = 1'b0;
        done = 1'b0;
        out_ready = 1'b1;
        load(8'd1);
        #12;
        chk("rst_valid",   32'(out_valid), 0);
        chk("rst_last",    32'(out_last),  0);
        chk("rst_data",    32'(out_data),  0);
        chk("rst_row",     32'(out_row),   0);
        chk("rst_col",     32'(out_col),   0);
        chk("rst_busy",    32'(busy),      0);
        chk("rst_overrun", 32'(overrun),   0);
        step();
        rst_n = 1'b1;
        step();

        // basic drain with one stall, driven from the vector table
        done = 1'b1;
        chk("basic_pre_valid", 32'(out_valid), 0);
        step();
        done = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_data", i),  32'(out_data),  32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_row", i),   32'(out_row),   32'(vecs[i].exp_row));
            chk($sformatf("vec%0d_col", i),   32'(out_col),   32'(vecs[i].exp_col));
            chk($sformatf("vec%0d_last", i),  32'(out_last),  32'(vecs[i].exp_last));
            chk($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].exp_busy));
            out_ready = vecs[i].ready;
            step();
        end

        // backpressure: ready pattern 1,0,0,1 repeating
        load(8'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        hs = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 60 && hs < 9; c++) begin
            if (prev_stall) begin
                chk("bp_hold_valid", 32'(out_valid), 1);
                chk("bp_hold_data",  32'(out_data),  32'(prev_data));
            end
            out_ready = pat[c % 4] != 0;
            if (out_valid && out_ready) begin
                expect_elem("bp", 8'd1, hs);
                hs++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            step();
        end
        chk("bp_count", 32'(hs), 9);
        chk("bp_idle_valid", 32'(out_valid), 0);

        // second done mid-stream is dropped and flagged
        out_ready = 1'b1;
        load(8'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("ovr_before", 32'(overrun), 0);
        for (int k = 0; k < 9; k++) begin
            expect_elem("ovr", 8'd1, k);
            if (k == 3) begin
                load(8'hA0);
                done = 1'b1;
            end else begin
                done = 1'b0;
            end
            step();
        end
        done = 1'b0;
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_idle_valid", 32'(out_valid), 0);
        step();
        step();
        step();
        chk("ovr_sticky", 32'(overrun), 1);

        // back-to-back recapture on the last handshake
        pulse_reset();
        chk("b2b_ovr_cleared", 32'(overrun), 0);
        load(8'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        for (int k = 0; k < 9; k++) begin
            expect_elem("b2b_first", 8'd1, k);
            if (k == 8) begin
                load(8'h10);
                done = 1'b1;
            end
            step();
        end
        done = 1'b0;
        chk("b2b_gapless_valid", 32'(out_valid), 1);
        chk("b2b_overrun", 32'(overrun), 0);
        chk("b2b_busy", 32'(busy), 1);
        load(8'hEE);
        drain_rest("b2b_second", 8'h10, 0);

        // done held two cycles in idle: captured once, extra cycle flagged
        load(8'h20);
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        chk("hold_overrun", 32'(overrun), 1);
        expect_elem("hold", 8'h20, 1);
        drain_rest("hold", 8'h20, 1);

        // asynchronous reset in the middle of a stream
        pulse_reset();
        load(8'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_elem("mid", 8'd1, k);
            step();
        end
        chk("mid_pre_row_or_col", 32'(out_row != 0 || out_col != 0), 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data",  32'(out_data),  0);
        chk("mid_rst_row",   32'(out_row),   0);
        chk("mid_rst_col",   32'(out_col),   0);
        chk("mid_rst_last",  32'(out_last),  0);
        chk("mid_rst_busy",  32'(busy),      0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_after_valid", 32'(out_valid), 0);
        load(8'h55);
        done = 1'b1;
        step();
        done = 1'b0;
        drain_rest("mid_new", 8'h55, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
